// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer and its screen-clear raster.
// Contents:
//   SCREEN_W / SCREEN_H  frame size; coordinates at or beyond these are clipped
//   CLEAR_COLOUR         colour written while the frame is being cleared
//   colour_t             3-bit pixel colour
//   seq_state_t          sequencer states IDLE, CLEAR, CIRC, DONE
// The CLEAR state only exists in builds with CLEAR_SCREEN_EN defined. Its
// encoding is still reserved so that dbg_state means the same thing in every
// build.
package draw_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  typedef logic [2:0] colour_t;

  localparam colour_t CLEAR_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    CIRC  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/draw_sequencer_screen_clear.sv
// screen_clear: column-major raster generator for the clear phase.
// The counter walks x from 0 to SCREEN_W-1 in the outer loop and y from 0 to
// SCREEN_H-1 in the inner loop.
// Ports:
//   clk, rst_n  clock; synchronous active-low reset (counter back to 0,0)
//   go          advance to the next pixel this cycle
//   x, y        pixel the counter currently holds
//   last        high while (x, y) is the final pixel of the frame
// When go is high while last is high, the counter wraps to (0,0). This leaves
// it ready for the next clear without a separate restart input.
// The parent only instantiates this module when CLEAR_SCREEN_EN is defined.
module screen_clear
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;

  assign last = (x_q == SCREEN_W - 8'd1) && (y_q == SCREEN_H - 7'd1);
  assign x    = x_q;
  assign y    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (go) begin
      if (last) begin
        x_d = '0;
        y_d = '0;
      end else if (y_q == SCREEN_H - 7'd1) begin
        x_d = x_q + 8'd1;
        y_d = '0;
      end else begin
        y_d = y_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: optionally clears the 160x120 frame, then runs the circle
// engine and forwards its pixels to the VGA adapter. Off-screen pixels are
// dropped.
// Build option: CLEAR_SCREEN_EN
//   defined    the sequence is IDLE -> CLEAR -> CIRC -> DONE
//   undefined  the sequence is IDLE -> CIRC -> DONE; no clear logic is built
// Ports:
//   clk, rst_n                     clock; synchronous active-low reset
//   start / done                   upstream request handshake
//   colour, centre_x/y, radius     circle operands, latched when start is accepted
//   c_colour, c_centre_x/y, c_radius   latched operands driven to the engine
//   circ_start / circ_done         engine handshake
//   circ_x/y/colour/plot           engine pixel stream
//   vga_x/y/colour/plot            registered pixel stream to the adapter
//   dbg_state                      current seq_state_t encoding
// Handshake: start is accepted only in IDLE. From then on, start is ignored
// until the sequencer reaches DONE. done stays high in DONE for as long as
// start stays high. The first cycle with start low returns the sequencer to
// IDLE, and done and circ_start fall on the same edge. A new request therefore
// needs start to be low for at least one cycle.
module draw_sequencer
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       circ_start,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_colour,
  input  logic       circ_plot,
  output logic [2:0] c_colour,
  output logic [7:0] c_centre_x,
  output logic [6:0] c_centre_y,
  output logic [7:0] c_radius,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [1:0] dbg_state
);

  seq_state_t state_q, state_d;
  colour_t    c_colour_q, c_colour_d;
  logic [7:0] c_centre_x_q, c_centre_x_d;
  logic [6:0] c_centre_y_q, c_centre_y_d;
  logic [7:0] c_radius_q, c_radius_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  colour_t    vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

`ifdef CLEAR_SCREEN_EN
  logic       clr_go;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic       clr_last;

  screen_clear u_screen_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (clr_go),
    .x     (clr_x),
    .y     (clr_y),
    .last  (clr_last)
  );
`endif

  always_comb begin
    state_d      = state_q;
    c_colour_d   = c_colour_q;
    c_centre_x_d = c_centre_x_q;
    c_centre_y_d = c_centre_y_q;
    c_radius_d   = c_radius_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
`ifdef CLEAR_SCREEN_EN
    clr_go       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          c_colour_d   = colour;
          c_centre_x_d = centre_x;
          c_centre_y_d = centre_y;
          c_radius_d   = radius;
`ifdef CLEAR_SCREEN_EN
          // The raster rests at (0,0). Register it on the accept edge so
          // the first clear pixel appears in the cycle after accept.
          state_d      = CLEAR;
          vga_x_d      = clr_x;
          vga_y_d      = clr_y;
          vga_colour_d = CLEAR_COLOUR;
          vga_plot_d   = 1'b1;
          clr_go       = 1'b1;
`else
          state_d      = CIRC;
`endif
        end
      end
`ifdef CLEAR_SCREEN_EN
      CLEAR: begin
        vga_x_d      = clr_x;
        vga_y_d      = clr_y;
        vga_colour_d = CLEAR_COLOUR;
        vga_plot_d   = 1'b1;
        clr_go       = 1'b1;
        if (clr_last) begin
          state_d = CIRC;
        end
      end
`endif
      CIRC: begin
        // Coordinates and colour are always forwarded. Only the write
        // strobe is gated. An engine coordinate that has wrapped past the
        // edge (for example x=250) fails this unsigned compare and is clipped.
        vga_x_d      = circ_x;
        vga_y_d      = circ_y;
        vga_colour_d = circ_colour;
        vga_plot_d   = circ_plot && (circ_x < SCREEN_W) && (circ_y < SCREEN_H);
        if (circ_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      c_colour_q   <= '0;
      c_centre_x_q <= '0;
      c_centre_y_q <= '0;
      c_radius_q   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_colour_q   <= c_colour_d;
      c_centre_x_q <= c_centre_x_d;
      c_centre_y_q <= c_centre_y_d;
      c_radius_q   <= c_radius_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  // circ_start stays high through DONE so that the engine keeps circ_done
  // asserted until upstream releases start.
  assign circ_start = (state_q == CIRC) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;
  assign c_colour   = c_colour_q;
  assign c_centre_x = c_centre_x_q;
  assign c_centre_y = c_centre_y_q;
  assign c_radius   = c_radius_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
